dice_controller: RTL

DICE_CONTROLLER -- requirements
Module: dice_controller

---
 rtl/dice_pkg.sv | 27 ++
 rtl/btn_sync.sv | 25 ++
 rtl/dice_controller.sv | 134 +++++++++++++
 3 files changed

// File: rtl/dice_pkg.sv
// Shared definitions for the dice game controller.
// State encoding, settle timing and score counter helpers.
package dice_pkg;

   localparam int SETTLE_CYCLES = 2;
   localparam int SETTLE_W      = 2;
   localparam int CNT_W         = 4;

   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0]    CNT_MAX     = '1;

   typedef enum logic [2:0] {
      S_IDLE1 = 3'd0,
      S_ROLL1 = 3'd1,
      S_EVAL1 = 3'd2,
      S_IDLE2 = 3'd3,
      S_ROLL2 = 3'd4,
      S_EVAL2 = 3'd5,
      S_WIN   = 3'd6,
      S_LOSE  = 3'd7
   } state_e;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for a raw push-button input.
// Async active-low reset clears both stages.
module btn_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic s1_q;
   logic s2_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= d;
         s2_q <= s1_q;
      end
   end

   assign q = s2_q;

endmodule

// File: rtl/dice_controller.sv
// Craps-style dice game controller: roll/evaluate FSM with
// synchronized buttons and saturating win/lose counters.
module dice_controller
   import dice_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             Rb,
   input  logic             New_game,
   input  logic             D7,
   input  logic             D711,
   input  logic             D2312,
   input  logic             Eq,
   output logic             Roll,
   output logic             Sp,
   output logic             Win,
   output logic             Lose,
   output logic [CNT_W-1:0] win_count,
   output logic [CNT_W-1:0] lose_count,
   output logic [2:0]       state_dbg
);

   logic rb_s;
   logic ng_s;

   btn_sync u_sync_rb (
      .clk (clk),
      .rst (rst),
      .d   (Rb),
      .q   (rb_s)
   );

   btn_sync u_sync_ng (
      .clk (clk),
      .rst (rst),
      .d   (New_game),
      .q   (ng_s)
   );

   state_e              state_q, state_d;
   logic [SETTLE_W-1:0] settle_q, settle_d;
   logic [CNT_W-1:0]    win_q, win_d;
   logic [CNT_W-1:0]    lose_q, lose_d;
   logic                ng_prev_q, ng_prev_d;

   logic decide;
   logic ng_rise;

   assign decide  = (settle_q == SETTLE_LAST);
   assign ng_rise = ng_s & ~ng_prev_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE1;
         settle_q  <= '0;
         win_q     <= '0;
         lose_q    <= '0;
         ng_prev_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         settle_q  <= settle_d;
         win_q     <= win_d;
         lose_q    <= lose_d;
         ng_prev_q <= ng_prev_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      settle_d  = '0;
      ng_prev_d = ng_s;
      Roll      = 1'b0;
      Sp        = 1'b0;
      Win       = 1'b0;
      Lose      = 1'b0;
      unique case (state_q)
         S_IDLE1: if (rb_s) state_d = S_ROLL1;
         S_ROLL1: begin
            Roll = 1'b1;
            if (!rb_s) state_d = S_EVAL1;
         end
         S_EVAL1: begin
            // Inputs only matter once the settle count expires
            if (!decide) begin
               settle_d = settle_q + 1'b1;
            end else if (D711) begin
               state_d = S_WIN;
            end else if (D2312) begin
               state_d = S_LOSE;
            end else begin
               Sp      = 1'b1;
               state_d = S_IDLE2;
            end
         end
         S_IDLE2: if (rb_s) state_d = S_ROLL2;
         S_ROLL2: begin
            Roll = 1'b1;
            if (!rb_s) state_d = S_EVAL2;
         end
         S_EVAL2: begin
            if (!decide) begin
               settle_d = settle_q + 1'b1;
            end else if (Eq) begin
               state_d = S_WIN;
            end else if (D7) begin
               state_d = S_LOSE;
            end else begin
               state_d = S_IDLE2;
            end
         end
         S_WIN: begin
            Win = 1'b1;
            if (ng_rise) state_d = S_IDLE1;
         end
         S_LOSE: begin
            Lose = 1'b1;
            if (ng_rise) state_d = S_IDLE1;
         end
         default: state_d = S_IDLE1;
      endcase
   end

   always_comb begin
      win_d  = win_q;
      lose_d = lose_q;
      if (state_d == S_WIN && state_q != S_WIN) win_d = sat_inc(win_q);
      if (state_d == S_LOSE && state_q != S_LOSE) lose_d = sat_inc(lose_q);
   end

   assign win_count  = win_q;
   assign lose_count = lose_q;
   assign state_dbg  = state_q;

endmodule
